mul_shift_add: RTL and testbench
================================

# mul_shift_add

Sequential shift-add multiply-accumulator computing p = q × b + r. It is the inverse of the team's restoring divider: it takes a 32-bit quotient, 16-bit divisor and 16-bit remainder and rebuilds the 48-bit dividend. It serves as the check path for divider results, and as a standalone multiplier when r = 0. It supports unsigned and two's-complement operands and uses the same start/busy/ready handshake as the divider.

## Interface
Parameters: none (widths fixed: q 32, b 16, r 16, p 48).
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  launch request, sampled on rising clk
- sgn  in  1  1 = q, b, r are two's complement; 0 = unsigned; sampled with start
- q  in  32  multiplicand (quotient), sampled with start
- b  in  16  multiplier (divisor), sampled with start
- r  in  16  addend (remainder), sampled with start
- p  out  48  result q × b + r; valid while ready = 1
- busy  out  1  iteration in progress
- ready  out  1  result valid; held until next accepted start or clr
- count  out  4  iteration index, for debug

## Operation
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1, 16 iterations.
  - DONE: ready = 1. DONE is equivalent to IDLE with ready held.
- Start acceptance: start is accepted only when busy = 0, i.e. in IDLE or DONE. start while busy = 1 is ignored; no state changes.
- On the accepting edge:
  - acc(48) ← r extended to 48 bits: sign-extended if sgn, else zero-extended.
  - mcand(48) ← q extended to 48 bits the same way.
  - mplr(16) ← b; sgn latched internally.
  - count ← 0, busy ← 1, ready ← 0.
- Each RUN cycle i = count (0..15):
  - If mplr[0] = 1: acc ← acc + mcand, except when i = 15 and latched sgn = 1, where acc ← acc − mcand (negative weight of b[15]).
  - mcand ← mcand << 1. mplr ← mplr >> 1. count ← count + 1.
- Arithmetic is modulo 2^48; no overflow can occur for either mode.
  - Unsigned maximum: 0xFFFF_0000_0000.
  - Signed range: within ±2^46 + 2^15.
- On iteration 15: busy ← 0, ready ← 1, count wraps to 0. p is driven by acc.
- p holds its value after completion. It updates only while busy (intermediate values visible, not valid).
- b = 0 requires no special case: p = extended r.

## Timing
- Reset (clr = 1 at a rising edge), regardless of state, including mid-RUN:
  - busy = 0, ready = 0, count = 0, p = 0.
  - Internal acc, mcand, mplr and latched sgn are cleared.
  - clr has priority over start in the same cycle.
- Latency:
  - Start accepted at edge N.
  - Iterations occur at edges N+1..N+16.
  - busy = 1 after edges N..N+15; busy = 0 and ready = 1 after edge N+16.
  - Total: 16 cycles start-to-ready, 17 including the load edge.
- Back-to-back: start held or asserted in the cycle where ready = 1 is accepted at that edge. ready drops after that edge; throughput is one result per 17 cycles.
- Input stability: inputs need to be valid only at the accepting edge. Changes during RUN have no effect.
- A start pulse of any length: a start held high re-launches after every completion.

## Test plan
1. Unsigned basic: sgn = 0, q = 100, b = 7, r = 3, start pulse → ready rises exactly 16 cycles after the accepting edge; p = 703 (0x2BF).
2. Unsigned maximum: q = 0xFFFFFFFF, b = 0xFFFF, r = 0xFFFF → p = 0xFFFF_0000_0000, no wrap.
3. Signed mixed: sgn = 1, q = 0xFFFFFFFB (−5), b = 3, r = 0xFFFE (−2) → p = 0xFFFF_FFFF_FFEF (−17). Also b = 0x8000 (−32768), q = 2, r = 0 → p = 0xFFFF_FFFF_0000.
4. Zero multiplier: sgn = 1, q = 0x12345678, b = 0, r = 0x8001 → p = 0xFFFF_FFFF_8001. With sgn = 0, same inputs → p = 0x0000_0000_8001.
5. Handshake: with q = 10, b = 10, r = 0, assert start again at cycle 5 of RUN with q = 1, b = 1 → ignored; p = 100. A new start while ready = 1 → ready falls next edge; new result after 16 more cycles.
6. Reset mid-operation: clr = 1 at RUN iteration 8 (with start also high) → next edge busy = 0, ready = 0, p = 0, count = 0. A subsequent start with q = 3, b = 4, r = 1 → p = 13.

Source files
------------

// File: rtl/mul_shift_add.sv
// Sequential shift-add multiply-accumulator: p = q * b + r over 16 iterations.
// Rebuilds a dividend from quotient/divisor/remainder; signed or unsigned.
module mul_shift_add (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] q,
  input  logic [15:0] b,
  input  logic [15:0] r,
  output logic [47:0] p,
  output logic        busy,
  output logic        ready,
  output logic [3:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] acc_q, acc_d;
  logic [47:0] mcand_q, mcand_d;
  logic [15:0] mplr_q, mplr_d;
  logic        sgn_q, sgn_d;
  logic [3:0]  count_q, count_d;
  logic        last_iter;

  assign last_iter = (count_q == 4'd15);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    sgn_d   = sgn_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = sgn ? {{32{r[15]}}, r} : {32'd0, r};
          mcand_d = sgn ? {{16{q[31]}}, q} : {16'd0, q};
          mplr_d  = b;
          sgn_d   = sgn;
          count_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // In signed mode the top multiplier bit carries weight -2^15, so it subtracts.
        if (mplr_q[0]) begin
          if (last_iter && sgn_q) acc_d = acc_q - mcand_q;
          else                    acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + 4'd1;
        if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      acc_q   <= 48'd0;
      mcand_q <= 48'd0;
      mplr_q  <= 16'd0;
      sgn_q   <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      sgn_q   <= sgn_d;
      count_q <= count_d;
    end
  end

  assign p     = acc_q;
  assign busy  = (state_q == RUN);
  assign ready = (state_q == DONE);
  assign count = count_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed self-checking bench for mul_shift_add with hand-computed products.
module tb_mul_shift_add;

  logic        clk;
  logic        clr;
  logic        start;
  logic        sgn;
  logic [31:0] q;
  logic [15:0] b;
  logic [15:0] r;
  logic [47:0] p;
  logic        busy;
  logic        ready;
  logic [3:0]  count;

  int checks;
  int errors;

  mul_shift_add dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .sgn   (sgn),
    .q     (q),
    .b     (b),
    .r     (r),
    .p     (p),
    .busy  (busy),
    .ready (ready),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present operands with start for exactly one rising edge, then confirm the launch.
  task automatic applyStimulus(input logic s, input logic [31:0] qv, input logic [15:0] bv, input logic [15:0] rv);
    @(negedge clk);
    sgn   = s;
    q     = qv;
    b     = bv;
    r     = rv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("launch_busy", {47'd0, busy}, 48'd1);
    checkOutput("launch_ready", {47'd0, ready}, 48'd0);
  endtask

  task automatic waitReady(input int expected_edges, input string tag);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ready && k < 40);
    checkOutput({tag, "_latency"}, 48'(k), 48'(expected_edges));
    checkOutput({tag, "_ready"}, {47'd0, ready}, 48'd1);
    checkOutput({tag, "_busy"}, {47'd0, busy}, 48'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr    = 1'b1;
    start  = 1'b0;
    sgn    = 1'b0;
    q      = 32'd0;
    b      = 16'd0;
    r      = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_p", p, 48'd0);
    checkOutput("reset_busy", {47'd0, busy}, 48'd0);
    checkOutput("reset_ready", {47'd0, ready}, 48'd0);
    checkOutput("reset_count", {44'd0, count}, 48'd0);
    @(negedge clk);
    clr = 1'b0;

    // Unsigned basic
    applyStimulus(1'b0, 32'd100, 16'd7, 16'd3);
    checkOutput("basic_count0", {44'd0, count}, 48'd0);
    waitReady(16, "basic");
    checkOutput("basic_p", p, 48'h0000_0000_02BF);
    checkOutput("basic_count_wrap", {44'd0, count}, 48'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("basic_p_hold", p, 48'h0000_0000_02BF);
    checkOutput("basic_ready_hold", {47'd0, ready}, 48'd1);

    // Unsigned maximum
    applyStimulus(1'b0, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
    waitReady(16, "umax");
    checkOutput("umax_p", p, 48'hFFFF_0000_0000);

    // Signed mixed
    applyStimulus(1'b1, 32'hFFFF_FFFB, 16'd3, 16'hFFFE);
    waitReady(16, "smix");
    checkOutput("smix_p", p, 48'hFFFF_FFFF_FFEF);
    applyStimulus(1'b1, 32'd2, 16'h8000, 16'd0);
    waitReady(16, "sneg_b");
    checkOutput("sneg_b_p", p, 48'hFFFF_FFFF_0000);

    // Zero multiplier
    applyStimulus(1'b1, 32'h1234_5678, 16'd0, 16'h8001);
    waitReady(16, "zero_s");
    checkOutput("zero_s_p", p, 48'hFFFF_FFFF_8001);
    applyStimulus(1'b0, 32'h1234_5678, 16'd0, 16'h8001);
    waitReady(16, "zero_u");
    checkOutput("zero_u_p", p, 48'h0000_0000_8001);

    // Handshake: start during RUN ignored
    applyStimulus(1'b0, 32'd10, 16'd10, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("hs_count4", {44'd0, count}, 48'd4);
    @(negedge clk);
    q     = 32'd1;
    b     = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("hs_ignored_busy", {47'd0, busy}, 48'd1);
    checkOutput("hs_ignored_count", {44'd0, count}, 48'd5);
    waitReady(11, "hs");
    checkOutput("hs_p", p, 48'd100);

    // Start while ready: accepted at the next edge
    applyStimulus(1'b0, 32'd3, 16'd5, 16'd2);
    waitReady(16, "b2b");
    checkOutput("b2b_p", p, 48'd17);

    // Reset mid-run with start also high
    applyStimulus(1'b0, 32'd10, 16'd10, 16'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    clr   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clr_busy", {47'd0, busy}, 48'd0);
    checkOutput("clr_ready", {47'd0, ready}, 48'd0);
    checkOutput("clr_p", p, 48'd0);
    checkOutput("clr_count", {44'd0, count}, 48'd0);
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    applyStimulus(1'b0, 32'd3, 16'd4, 16'd1);
    waitReady(16, "post_clr");
    checkOutput("post_clr_p", p, 48'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
